alu_mul_seq: RTL

//   Multi-cycle unsigned multiplier sequencer that reuses the shared 16-bit ALU
//   (add and right shift) instead of dedicated multiplier hardware.

---
 rtl/alu_mul_seq_pkg.sv | 25 ++
 rtl/alu_mul_seq_if.sv | 31 +++
 rtl/alu_mul_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU function codes and multiplier sequencer state encoding.
package alu_mul_seq_pkg;

    // Bank 0 function codes (alu_func2 = 0)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_LSH = 3'b101;
    localparam logic [2:0] ALU_RSH = 3'b110;

    // Bank 1 function codes (alu_func2 = 1)
    localparam logic [2:0] ALU_NOT = 3'b000;
    localparam logic [2:0] ALU_ROL = 3'b001;
    localparam logic [2:0] ALU_ROR = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ADD   = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result and shared-ALU lines between the multiplier sequencer and its parent.
interface alu_mul_seq_if #(
    parameter int WIDTH = 16
);
    logic               start;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic               ovf;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [2:0]         alu_func;
    logic               alu_func2;
    logic               alu_cin;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_c;

    // Sequencer side
    modport slave (
        input  start, op_a, op_b, alu_out, alu_c,
        output busy, done, product, ovf, alu_a, alu_b, alu_func, alu_func2, alu_cin
    );

    // Parent side: issues requests and hosts the shared ALU
    modport master (
        output start, op_a, op_b, alu_out, alu_c,
        input  busy, done, product, ovf, alu_a, alu_b, alu_func, alu_func2, alu_cin
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier that borrows the shared ALU for every add and shift step.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_mul_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    mul_state_e           state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     acc_hi_q;
    logic [WIDTH-1:0]     acc_lo_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 carry_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ovf_q;
    logic [2*WIDTH-1:0]   product_q;
    logic [WIDTH-1:0]     alu_a_q;
    logic [WIDTH-1:0]     alu_b_q;
    logic [2:0]           alu_func_q;
    logic [WIDTH-1:0]     sh_hi_d;
    logic [WIDTH-1:0]     sh_lo_d;

    function automatic logic [WIDTH-1:0] addend(input logic sel, input logic [WIDTH-1:0] m);
        return sel ? m : '0;
    endfunction

    // The ADD carry re-enters at the top while the ALU's shift-out bit feeds the low half.
    always_comb begin
        sh_hi_d = {carry_q, bus.alu_out[WIDTH-2:0]};
        sh_lo_d = {bus.alu_c, acc_lo_q[WIDTH-1:1]};
    end

    // Sequencer FSM; ALU operands are registered here so they hold steady for a full step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mcand_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            product_q  <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_func_q <= ALU_ADD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= bus.start;
                    if (bus.start) begin
                        mcand_q    <= bus.op_a;
                        acc_lo_q   <= bus.op_b;
                        acc_hi_q   <= '0;
                        cnt_q      <= '0;
                        carry_q    <= 1'b0;
                        alu_a_q    <= addend(bus.op_b[0], bus.op_a);
                        alu_b_q    <= '0;
                        alu_func_q <= ALU_ADD;
                        state_q    <= S_ADD;
                    end else begin
                        alu_a_q    <= '0;
                        alu_b_q    <= '0;
                        alu_func_q <= ALU_ADD;
                        state_q    <= S_IDLE;
                    end
                end
                S_ADD: begin
                    acc_hi_q   <= bus.alu_out;
                    carry_q    <= bus.alu_c;
                    alu_a_q    <= ONE_W;
                    alu_b_q    <= bus.alu_out;
                    alu_func_q <= ALU_RSH;
                    state_q    <= S_SHIFT;
                end
                S_SHIFT: begin
                    acc_hi_q <= sh_hi_d;
                    acc_lo_q <= sh_lo_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        alu_a_q    <= '0;
                        alu_b_q    <= '0;
                        alu_func_q <= ALU_ADD;
                        state_q    <= S_DONE;
                    end else begin
                        alu_a_q    <= addend(sh_lo_d[0], mcand_q);
                        alu_b_q    <= sh_hi_d;
                        alu_func_q <= ALU_ADD;
                        state_q    <= S_ADD;
                    end
                end
                S_DONE: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b1;
                    product_q  <= {acc_hi_q, acc_lo_q};
                    ovf_q      <= |acc_hi_q;
                    alu_a_q    <= '0;
                    alu_b_q    <= '0;
                    alu_func_q <= ALU_ADD;
                    state_q    <= S_IDLE;
                end
                default: begin
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    alu_a_q    <= '0;
                    alu_b_q    <= '0;
                    alu_func_q <= ALU_ADD;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.product   = product_q;
    assign bus.ovf       = ovf_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_func  = alu_func_q;
    assign bus.alu_func2 = 1'b0;
    assign bus.alu_cin   = 1'b0;

endmodule
